// File: rtl/btn_axi_ip.sv
// Debounced button block with sticky rise/fall events, a press counter and a level irq.
// Status and write-1-to-clear paths are meant to sit behind an AXI-lite register slave.
module btn_axi_ip #(
    parameter int N_BTN     = 4,
    parameter int DB_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    input  logic             clr_we,
    input  logic [31:0]      clr_data,
    output logic [31:0]      rd_reg,
    output logic             irq
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [N_BTN-1:0] sync1_q, sync1_d;
    logic [N_BTN-1:0] sync2_q, sync2_d;
    logic [N_BTN-1:0] stable_q, stable_d;
    logic [CW-1:0]    cnt_q [N_BTN];
    logic [CW-1:0]    cnt_d [N_BTN];
    logic [N_BTN-1:0] rise_q, rise_d;
    logic [N_BTN-1:0] fall_q, fall_d;
    logic [15:0]      press_q, press_d;
    logic             irq_q, irq_d;

    logic [N_BTN-1:0] rise_evt, fall_evt;
    logic [N_BTN-1:0] clr_rise, clr_fall;
    logic [2:0]       rise_cnt;
    logic             unused_clr_bits;

    assign unused_clr_bits = ^{clr_data[31:17], clr_data[15:12], clr_data[3:0]};

    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
    end

    // A mismatch must survive DB_CYCLES consecutive cycles; any agreement restarts the count.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        rise_evt = stable_d & ~stable_q;
        fall_evt = stable_q & ~stable_d;
        clr_rise = clr_we ? clr_data[4 +: N_BTN] : '0;
        clr_fall = clr_we ? clr_data[8 +: N_BTN] : '0;
        rise_cnt = '0;
        for (int i = 0; i < N_BTN; i++) begin
            rise_cnt = rise_cnt + {2'b00, rise_evt[i]};
        end
        // New events win over a simultaneous clear.
        rise_d  = (rise_q & ~clr_rise) | rise_evt;
        fall_d  = (fall_q & ~clr_fall) | fall_evt;
        press_d = ((clr_we && clr_data[16]) ? 16'h0000 : press_q) + 16'(rise_cnt);
        irq_d   = (|rise_q) | (|fall_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            press_q  <= '0;
            irq_q    <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            press_q  <= press_d;
            irq_q    <= irq_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rd_reg = {press_q, 4'b0000, 4'(fall_q), 4'(rise_q), 4'(stable_q)};
    assign irq    = irq_q;

endmodule

// File: doc/btn_axi_ip.md
BTN_AXI_IP -- requirements
Module: btn_axi_ip

Interface
REQ-001 SHALL have parameter N_BTN, default 4, meaning number of button inputs; legal range 1..4.
REQ-002 SHALL have parameter DB_CYCLES, default 100000, meaning consecutive stable cycles required to accept a level change; legal range 2..2^20.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port btn_in  input  N_BTN  raw button levels, asynchronous to clk, bouncing.
REQ-006 SHALL have port clr_we  input  1  one-cycle write strobe from the AXI slave register write path.
REQ-007 SHALL have port clr_data  input  32  write-1-to-clear mask, valid when clr_we=1.
REQ-008 SHALL have port rd_reg  output  32  status word presented to the AXI slave register read path.
REQ-009 SHALL have port irq  output  1  registered level interrupt, high while any sticky event bit is set.

Function
REQ-010 SHALL pass each btn_in bit through a 2-flop synchronizer before any other use.
REQ-011 SHALL keep per button a debounced level (stable) and a debounce counter wide enough for DB_CYCLES-1.
REQ-012 SHALL clear a button's counter on any cycle where the synchronized level equals stable.
REQ-013 SHALL increment the counter each cycle where the synchronized level differs from stable and the counter is below DB_CYCLES-1.
REQ-014 SHALL, on the edge where the counter equals DB_CYCLES-1 and the mismatch persists, load stable with the synchronized level and clear the counter; a bounce back before then restarts from 0.
REQ-015 SHALL therefore update stable exactly DB_CYCLES cycles after the synchronized level first differs, i.e. DB_CYCLES+2 clk edges after a clean btn_in change.
REQ-016 SHALL set rise sticky bit i on the same edge stable[i] goes 0->1, and fall sticky bit i on the same edge stable[i] goes 1->0.
REQ-017 SHALL increment a 16-bit press counter once per rise event on any button, wrapping 0xFFFF->0x0000; simultaneous rises on k buttons add k.
REQ-018 SHALL map rd_reg combinationally from registers: [3:0] stable, [7:4] rise sticky, [11:8] fall sticky, [15:12] zero, [31:16] press counter; bits for buttons >= N_BTN read 0.
REQ-019 SHALL, on clr_we=1, clear rise sticky bits where clr_data[7:4]=1, fall sticky bits where clr_data[11:8]=1, and the press counter when clr_data[16]=1; other clr_data bits ignored.
REQ-020 SHALL give set priority over clear: an event and a clear of the same sticky bit on the same edge leaves the bit set.
REQ-021 SHALL, if a counter clear and a rise coincide, load the press counter with the number of rises on that edge.
REQ-022 SHALL drive irq from a flop equal to the OR of all rise and fall sticky bits, one cycle after they change.

Reset
REQ-023 SHALL, while rst=1, asynchronously force synchronizer flops, stable, debounce counters, sticky bits, press counter and irq to 0, so rd_reg=0x00000000.
REQ-024 SHALL, after rst deasserts with buttons held high, treat them as a 0->1 change: full debounce, then rise event.
REQ-025 SHALL discard any in-progress debounce on reset; no event is generated from pre-reset history.

Verification (bench uses N_BTN=4, DB_CYCLES=4)
REQ-026 SHALL cover clean press: btn_in[0] 0->1 held -> rd_reg[0]=1, rd_reg[4]=1, rd_reg[31:16]=1 exactly 6 edges later; irq=1 one edge after that.
REQ-027 SHALL cover bounce: btn_in[1] toggles with 3-cycle high pulses 5 times -> rd_reg stays 0x00000000, irq=0.
REQ-028 SHALL cover clear: after REQ-026, clr_we=1, clr_data=0x00010010 -> rd_reg=0x00000001 next edge, irq=0 one edge later.
REQ-029 SHALL cover set-vs-clear collision: clear of bit 4 on the same edge a new rise of button 0 lands -> rd_reg[4]=1.
REQ-030 SHALL cover wrap: 65536 press/release cycles on btn_in[2] -> rd_reg[31:16]=0x0000, rd_reg[6]=1, rd_reg[10]=1.
REQ-031 SHALL cover reset mid-debounce: rst pulsed 2 cycles into a btn_in[3] mismatch -> rd_reg=0 immediately, event appears only DB_CYCLES+2 edges after rst release.
